prime_scan_ctrl: RTL and testbench



---
 rtl/prime_pkg.sv | 35 +++
 rtl/prime.sv | 27 ++
 rtl/prime_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_prime_scan_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// prime_pkg: constants and types shared by the prime lookup and its scan
// sequencer.
//   N_W      operand width of the lookup
//   MAX_N    highest operand covered by the lookup table
//   CNT_W    prime counter width (72 primes in 0..360)
//   scan_state_t  sequencer states
//   prime_table() builds the primality bit vector for 0..MAX_N at elaboration
package prime_pkg;

    localparam int N_W   = 9;
    localparam int MAX_N = 360;
    localparam int CNT_W = 7;

    localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // Bit n is set when n is prime. Evaluated as a constant function.
    function automatic logic [MAX_N:0] prime_table();
        logic [MAX_N:0] t;
        for (int n = 0; n <= MAX_N; n++) begin
            t[n] = (n >= 2);
            for (int d = 2; d * d <= n; d++) begin
                if (n % d == 0) t[n] = 1'b0;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/prime.sv
// prime: registered primality lookup for 0..MAX_N.
//   clk     system clock, rising edge
//   reset   asynchronous, active-high
//   number  operand to look up
//   result  1 when the operand presented last cycle is prime
// Operands above MAX_N are not covered; for them result holds its
// previous value, so the consumer must mask them.
module prime
    import prime_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [N_W-1:0] number,
    output logic           result
);

    localparam logic [MAX_N:0] TABLE = prime_table();

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= 1'b0;
        end else if (number <= MAX_N_V) begin
            result <= TABLE[number];
        end
    end

endmodule

// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl: walks a number range through the prime lookup one
// operand per clock, counting primes (COUNT) or stopping at the first
// prime (FIND).
//   clk, reset   clock and asynchronous active-high reset
//   start        one-cycle request, sampled only in IDLE
//   mode         0 = COUNT, 1 = FIND (latched with start)
//   lo, hi       inclusive range bounds (latched with start, hi clipped to MAX_N)
//   busy         high whenever the state is not IDLE
//   done         one-cycle completion pulse
//   found        FIND located a prime
//   count        primes seen in the scanned range
//   value        located prime in FIND, else 0
//   dbg_state_o  current sequencer state
// Handshake: start is a single-cycle request accepted only while busy is
// low; a start seen while busy is dropped, never queued.
module prime_scan_ctrl
    import prime_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [N_W-1:0]   lo,
    input  logic [N_W-1:0]   hi,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [CNT_W-1:0] count,
    output logic [N_W-1:0]   value,
    output scan_state_t      dbg_state_o
);

    scan_state_t    state_q;
    logic           mode_q;
    logic [N_W-1:0] hi_q;
    logic [N_W-1:0] cur_q;
    logic           tag_vld_q;
    logic [N_W-1:0] tag_val_q;
    logic           result;
    logic [N_W-1:0] hi_eff;
    logic           hit;

    assign hi_eff      = (hi > MAX_N_V) ? MAX_N_V : hi;
    assign dbg_state_o = state_q;

    // The tag pairs each lookup result with the operand that produced it,
    // one cycle after issue. Operands beyond the table are forced non-prime.
    assign hit = tag_vld_q && result && (tag_val_q <= MAX_N_V);

    prime u_prime (
        .clk    (clk),
        .reset  (reset),
        .number (cur_q),
        .result (result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            hi_q      <= '0;
            cur_q     <= '0;
            tag_vld_q <= 1'b0;
            tag_val_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            count     <= '0;
            value     <= '0;
        end else begin
            done      <= 1'b0;
            tag_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        hi_q   <= hi_eff;
                        count  <= '0;
                        found  <= 1'b0;
                        value  <= '0;
                        busy   <= 1'b1;
                        if (lo > hi_eff) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else begin
                            cur_q   <= lo;
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (hit && mode_q) begin
                        // First prime in FIND: abandon the operand issued this cycle.
                        count   <= count + CNT_W'(1);
                        found   <= 1'b1;
                        value   <= tag_val_q;
                        state_q <= DONE;
                        done    <= 1'b1;
                    end else begin
                        if (hit) count <= count + CNT_W'(1);
                        tag_vld_q <= 1'b1;
                        tag_val_q <= cur_q;
                        if (cur_q == hi_q) state_q <= DRAIN;
                        else               cur_q   <= cur_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (hit) begin
                        count <= count + CNT_W'(1);
                        if (mode_q) begin
                            found <= 1'b1;
                            value <= tag_val_q;
                        end
                    end
                    state_q <= DONE;
                    done    <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Bench for prime_scan_ctrl: directed range jobs plus random jobs checked
// against a behavioural range model, an ignored mid-scan start and a
// mid-scan reset.
module tb_prime_scan_ctrl;
    import prime_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic [N_W-1:0]   lo;
    logic [N_W-1:0]   hi;
    logic             busy;
    logic             done;
    logic             found;
    logic [CNT_W-1:0] count;
    logic [N_W-1:0]   value;
    scan_state_t      dbg_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    // clock/reset block
    always #5 clk = ~clk;

    prime_scan_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .lo          (lo),
        .hi          (hi),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .count       (count),
        .value       (value),
        .dbg_state_o (dbg_state)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: expected count, found, value and done cycle for one job.
    task automatic model(input bit m, input int l, input int h);
        int he;
        int c;
        int f;
        int v;
        int dc;
        he = (h > MAX_N) ? MAX_N : h;
        c = 0; f = 0; v = 0;
        if (l > he) begin
            dc = 1;
        end else begin
            dc = he - l + 3;
            for (int n = l; n <= he; n++) begin
                if (is_prime(n)) begin
                    c++;
                    if (m) begin
                        f = 1;
                        v = n;
                        dc = n - l + 3;
                        break;
                    end
                end
            end
        end
        exp_q.push_back(32'(c));
        exp_q.push_back(32'(f));
        exp_q.push_back(32'(v));
        exp_q.push_back(32'(dc));
    endtask

    // driver: called just after a falling edge; start is high in cycle 0.
    task automatic run_job(input bit m, input int l, input int h, input bit poke);
        int cyc;
        int e_c;
        int e_f;
        int e_v;
        int e_dc;
        model(m, l, h);
        e_c  = int'(exp_q.pop_front());
        e_f  = int'(exp_q.pop_front());
        e_v  = int'(exp_q.pop_front());
        e_dc = int'(exp_q.pop_front());
        start = 1'b1;
        mode  = m;
        lo    = N_W'(l);
        hi    = N_W'(h);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 600) begin
            chk("busy_scan", int'(busy), 1);
            if (poke && cyc == 3) begin
                start = 1'b1;
                mode  = ~m;
                lo    = N_W'(0);
                hi    = N_W'(5);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_cycle", cyc, e_dc);
        chk("busy_at_done", int'(busy), 1);
        chk("count", int'(count), e_c);
        chk("found", int'(found), e_f);
        chk("value", int'(value), e_v);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
        chk("count_hold", int'(count), e_c);
        chk("value_hold", int'(value), e_v);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        lo    = '0;
        hi    = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_state", int'(dbg_state), int'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        run_job(1'b0, 0, 10, 1'b0);
        run_job(1'b1, 24, 100, 1'b0);
        run_job(1'b1, 24, 28, 1'b0);
        run_job(1'b0, 350, 511, 1'b0);
        run_job(1'b0, 20, 10, 1'b0);
        run_job(1'b0, 0, 360, 1'b1);
        run_job(1'b1, 361, 511, 1'b0);
        run_job(1'b1, 359, 400, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int l;
            int h;
            l = int'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) h = int'($urandom_range(0, 511));
            else h = (l + int'($urandom_range(0, 40)) > 511) ? 511 : l + int'($urandom_range(0, 40));
            run_job(1'($urandom_range(0, 1)), l, h, 1'($urandom_range(0, 1)));
        end

        // Reset in cycle 5 of a full-range COUNT.
        start = 1'b1;
        mode  = 1'b0;
        lo    = N_W'(0);
        hi    = N_W'(360);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_found", int'(found), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_value", int'(value), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
        end
        run_job(1'b0, 2, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
